spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- SPI mode-0 initiator that streams a byte range out of an external serial flash. It speaks the other end of the flash responder protocol.
- Used inside the user project to copy a jacaranda-8 program image from flash into instruction memory after reset.
- Issues READ (0x03) plus a 24-bit address, then shifts in bytes continuously.
- Each byte is delivered on a valid/ready stream; SCK pauses when the consumer back-pressures.

Parameters:
- CLK_DIV, 2, system clocks per SCK half-period (legal range 1..255).
- LEN_W, 16, width of the byte-count input.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- resetb  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- addr  input  24  flash start byte address, captured on accepted start.
- len  input  LEN_W  bytes to read, captured on accepted start; 0 means no transfer.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the transfer completes.
- rd_data  output  8  received byte, MSB first on the wire.
- rd_valid  output  1  rd_data holds an unconsumed byte.
- rd_ready  input  1  consumer accepts rd_data when rd_valid and rd_ready are both high.
- flash_csb  output  1  chip select, active low.
- flash_clk  output  1  SCK; idles low.
- flash_io0  output  1  MOSI.
- flash_io1  input  1  MISO.

Behaviour:
- Reset (resetb=0 at a clock edge) sets: flash_csb=1, flash_clk=0, flash_io0=0, busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE.
- Reset mid-transfer aborts immediately. CS deasserts on that same edge and no done pulse is produced.
- FSM states: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA -> CS_HOLD -> IDLE.
- IDLE:
  - start=1 with len!=0: capture addr and len, go to CS_SETUP, busy=1.
  - start=1 with len==0: pulse done for one cycle and stay in IDLE; busy stays 0.
- CS_SETUP: flash_csb=0, then wait CLK_DIV clocks before the first SCK rise.
- SCK generation:
  - Divider counter toggles flash_clk every CLK_DIV clocks.
  - flash_io0 changes only while flash_clk is low, just after a falling edge, or during CS_SETUP for the first bit.
  - flash_io1 is sampled on the rising edge of flash_clk.
- CMD: shift 8 bits of 0x03, MSB first.
- ADDR: shift 24 address bits, MSB first.
- DATA:
  - Shift in 8 bits per byte. After the 8th rising-edge sample, load rd_data on the next clock and set rd_valid=1. Also decrement the remaining count.
  - If a previous byte is still pending (rd_valid=1 and not accepted), hold flash_clk low and freeze the divider until the handshake completes. No byte is ever dropped or overwritten.
  - rd_valid clears on the handshake cycle unless a new byte loads in that same cycle; if it does, rd_valid stays 1 with the new data.
  - When the remaining count reaches 0 after the last byte is sampled, go to CS_HOLD without generating further SCK edges.
- CS_HOLD:
  - Wait for the last byte to be consumed (rd_valid=0).
  - Then hold flash_csb low for CLK_DIV more clocks, then drive flash_csb=1.
  - Pulse done for one cycle coinciding with the busy 1->0 transition, then return to IDLE.
- start while busy is ignored.
- Address is not incremented by the block; the flash auto-increments. Reads crossing 0xFFFFFF wrap per the flash's own behaviour.
- Transfer length is len bytes exactly. Throughput with rd_ready held high is one byte per 16*CLK_DIV clocks.

Optional Feature:
- Macro SPI_FLASH_READER_FASTREAD_EN.
- Defined:
  - The command byte is 0x0B (FAST_READ).
  - ADDR is followed by a DUMMY state of 8 SCK cycles with flash_io0=0 and no data sampled, then DATA.
- Undefined:
  - The command byte is 0x03, with no DUMMY state and no dummy logic synthesized.

Test Plan:
1. Reset behaviour: hold resetb=0 for 5 clocks -> flash_csb=1, flash_clk=0, busy=0, rd_valid=0. Pulse start while resetb=0 -> no CS activity.
2. Basic read with CLK_DIV=2:
   - Stimulus: flash model preloaded with 0x93,0x00,0x41,0x7F at 0x100000; start with addr=0x100000, len=4, rd_ready=1.
   - Required wire sequence: 0x03,0x10,0x00,0x00.
   - Required stream output: bytes 0x93,0x00,0x41,0x7F, then one done pulse, then flash_csb=1.
3. Back-pressure: same read with rd_ready=0 for 40 clocks after the first byte -> flash_clk holds low with no edges and rd_data stays 0x93. On release, all 4 bytes arrive in order.
4. Zero length: start with len=0 -> done pulses the next cycle; flash_csb never goes low; busy stays 0.
5. Abort: assert resetb=0 mid-ADDR -> flash_csb=1 the following edge, no done pulse. A subsequent start with len=1 reads the correct byte.
6. With SPI_FLASH_READER_FASTREAD_EN defined: start with addr=0x100000, len=2 -> wire shows 0x0B, the address, then 8 dummy clocks, then bytes 0x93,0x00.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI mode-0 initiator: issues READ + 24-bit address, streams len bytes onto a valid/ready port.
// Define SPI_FLASH_READER_FASTREAD_EN for FAST_READ (0x0B) with 8 dummy SCK cycles after the address.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic             flash_io0,
    input  logic             flash_io1
);

`ifdef SPI_FLASH_READER_FASTREAD_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
    typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD} state_t;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
    typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD} state_t;
`endif
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_div;
    logic             r_sck;
    logic [31:0]      r_tx;
    logic [7:0]       r_rx;
    logic [4:0]       r_cnt;
    logic [LEN_W-1:0] r_remaining;
    logic             r_last;
    logic             r_load;
    logic             r_done;
    logic [7:0]       r_rd_data;
    logic             r_rd_valid;

    logic w_shifting, w_div_end, w_stall, w_tick, w_rise, w_fall;
    logic w_hs, w_accept, w_zero_len, w_hold_end, w_bit_last;

    always_comb begin
        w_shifting = (r_state != IDLE) && (r_state != CS_HOLD);
        w_div_end  = (r_div == DIV_LAST);
        // A pending byte parks SCK low with the divider frozen so nothing is overwritten.
        w_stall    = (r_state == DATA) && r_rd_valid && !rd_ready && !r_sck;
        w_tick     = w_shifting && w_div_end && !w_stall;
        w_rise     = w_tick && !r_sck;
        w_fall     = w_tick && r_sck;
        w_hs       = r_rd_valid && rd_ready;
        w_accept   = (r_state == IDLE) && start && (len != '0);
        w_zero_len = (r_state == IDLE) && start && (len == '0);
        w_hold_end = (r_state == CS_HOLD) && !r_rd_valid && w_div_end;
        w_bit_last = (r_state == ADDR) ? (r_cnt == 5'd23) : (r_cnt == 5'd7);
    end

    always_ff @(posedge clock) begin
        if (!resetb) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // The CS_SETUP divider expiry is itself the first SCK rise, counted as command bit 0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = CS_SETUP;
            CS_SETUP: if (w_rise) w_next = CMD;
            CMD:      if (w_rise && w_bit_last) w_next = ADDR;
`ifdef SPI_FLASH_READER_FASTREAD_EN
            ADDR:     if (w_rise && w_bit_last) w_next = DUMMY;
            DUMMY:    if (w_rise && w_bit_last) w_next = DATA;
`else
            ADDR:     if (w_rise && w_bit_last) w_next = DATA;
`endif
            DATA:     if (w_fall && r_last) w_next = CS_HOLD;
            CS_HOLD:  if (w_hold_end) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        flash_csb = (r_state == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_div       <= '0;
            r_sck       <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_remaining <= '0;
            r_last      <= 1'b0;
            r_load      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= w_zero_len || w_hold_end;

            if ((r_state == IDLE) || ((r_state == CS_HOLD) && r_rd_valid) || (w_div_end && !w_stall))
                r_div <= '0;
            else if (!w_stall)
                r_div <= r_div + 8'd1;

            if (w_accept) begin
                r_tx        <= {CMD_BYTE, addr};
                r_remaining <= len;
                r_last      <= 1'b0;
                r_cnt       <= '0;
            end

            if (w_rise) begin
                r_sck <= 1'b1;
                r_cnt <= w_bit_last ? 5'd0 : r_cnt + 5'd1;
                if (r_state == DATA) begin
                    r_rx <= {r_rx[6:0], flash_io1};
                    if (w_bit_last) begin
                        r_load <= 1'b1;
                        r_last <= (r_remaining == LEN_W'(1));
                    end
                end
            end

            if (w_fall) begin
                r_sck <= 1'b0;
                r_tx  <= {r_tx[30:0], 1'b0};
            end

            if (r_load) begin
                r_rd_data   <= r_rx;
                r_rd_valid  <= 1'b1;
                r_remaining <= r_remaining - LEN_W'(1);
            end else if (w_hs) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign done      = r_done;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign flash_clk = r_sck;
    assign flash_io0 = r_tx[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a mode-0 flash responder model and a byte scoreboard.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_READER_FASTREAD_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam int unsigned HDR = 40;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam int unsigned HDR = 32;
`endif

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] len = '0;
    logic        rd_ready = 1'b0;
    logic        flash_io1 = 1'b0;
    logic        busy, done, rd_valid, flash_csb, flash_clk, flash_io0;
    logic [7:0]  rd_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    spi_flash_reader #(.CLK_DIV(2), .LEN_W(16)) dut (
        .clock(clock), .resetb(resetb), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash responder model
    logic [7:0]  mem [16];
    logic [7:0]  q_wire [$];
    logic [39:0] m_hdr = '0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_byte;
    int unsigned m_bits = 0;
    int unsigned m_j;
    int          m_idx;
    int unsigned sck_rises = 0;
    int unsigned cs_falls = 0;
    int unsigned dummy_hi = 0;

    always @(negedge flash_csb) begin
        cs_falls++;
        m_bits = 0;
    end
    always @(posedge flash_csb) m_bits = 0;

    always @(posedge flash_clk) begin
        sck_rises++;
        if (flash_csb === 1'b0) begin
            if (m_bits < HDR) begin
                m_hdr = {m_hdr[38:0], flash_io0};
                if (m_bits % 8 == 7) q_wire.push_back(m_hdr[7:0]);
                if (m_bits == 31) m_addr = m_hdr[23:0];
                if (m_bits >= 32 && flash_io0 !== 1'b0) dummy_hi++;
            end
            m_bits++;
        end
    end

    always @(negedge flash_clk) begin
        if (flash_csb === 1'b0 && m_bits >= HDR) begin
            m_j = m_bits - HDR;
            m_idx = int'(m_addr) - 32'h100000 + int'(m_j / 8);
            m_byte = (m_idx >= 0 && m_idx < 16) ? mem[m_idx] : 8'hFF;
            flash_io1 = m_byte[7 - (m_j % 8)];
        end
    end

    // Scoreboard consumer and pulse monitors
    logic [7:0]  q_exp [$];
    int unsigned hs_cyc [$];
    int unsigned cyc = 0;
    int unsigned n_rx = 0;
    int unsigned done_cnt = 0;
    logic [31:0] sb_exp;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (resetb && done) done_cnt++;
        if (resetb && rd_valid && rd_ready) begin
            sb_exp = (q_exp.size() > 0) ? {24'b0, q_exp.pop_front()} : 32'hDEAD;
            chk("rd_data", {24'b0, rd_data}, sb_exp);
            n_rx++;
            hs_cyc.push_back(cyc);
        end
    end

    task automatic chk_wire(input logic [23:0] a);
        logic [7:0] eb [4];
        eb = '{CMD, a[23:16], a[15:8], a[7:0]};
        chk("wire_len", q_wire.size(), HDR / 8);
        for (int i = 0; i < 4; i++)
            chk("wire_byte", (q_wire.size() > i) ? {24'b0, q_wire[i]} : 32'hDEAD, {24'b0, eb[i]});
        q_wire.delete();
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
        addr = a;
        len = n;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned k = 0;
        while (!done && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk(tag, {31'b0, done}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_csb"}, {31'b0, flash_csb}, 32'd1);
    endtask

    int unsigned k0, r0, c0, d0, n0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h41; mem[3] = 8'h7F;

        // 1: reset, with a start pulse while held
        @(negedge clock);
        pulse_start(24'h100000, 16'd4);
        repeat (4) @(negedge clock);
        chk("rst_csb", {31'b0, flash_csb}, 32'd1);
        chk("rst_sck", {31'b0, flash_clk}, 32'd0);
        chk("rst_io0", {31'b0, flash_io0}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_data", {24'b0, rd_data}, 32'd0);
        chk("rst_cs_falls", cs_falls, 32'd0);
        resetb = 1'b1;
        repeat (2) @(negedge clock);

        // 2: basic read, full throughput
        rd_ready = 1'b1;
        q_wire.delete();
        hs_cyc.delete();
        c0 = cs_falls; d0 = done_cnt; n0 = n_rx;
        q_exp.push_back(8'h93); q_exp.push_back(8'h00);
        q_exp.push_back(8'h41); q_exp.push_back(8'h7F);
        pulse_start(24'h100000, 16'd4);
        chk("basic_busy", {31'b0, busy}, 32'd1);
        wait_done("basic_done");
        repeat (3) @(negedge clock);
        chk("basic_nrx", n_rx - n0, 32'd4);
        chk("basic_sb_empty", q_exp.size(), 32'd0);
        chk("basic_done_cnt", done_cnt - d0, 32'd1);
        chk("basic_cs_falls", cs_falls - c0, 32'd1);
        chk("basic_rate01", (hs_cyc.size() >= 4) ? hs_cyc[1] - hs_cyc[0] : 32'hDEAD, 32'd32);
        chk("basic_rate23", (hs_cyc.size() >= 4) ? hs_cyc[3] - hs_cyc[2] : 32'hDEAD, 32'd32);
        chk_wire(24'h100000);

        // 3: back-pressure on the first byte
        rd_ready = 1'b0;
        n0 = n_rx; d0 = done_cnt;
        q_exp.push_back(8'h93); q_exp.push_back(8'h00);
        q_exp.push_back(8'h41); q_exp.push_back(8'h7F);
        pulse_start(24'h100000, 16'd4);
        k0 = 0;
        while (!rd_valid && k0 < 3000) begin
            @(negedge clock);
            k0++;
        end
        chk("bp_first_valid", {31'b0, rd_valid}, 32'd1);
        r0 = sck_rises;
        repeat (40) @(negedge clock);
        chk("bp_no_rise", sck_rises - r0, 32'd0);
        chk("bp_sck_low", {31'b0, flash_clk}, 32'd0);
        chk("bp_hold_data", {24'b0, rd_data}, 32'h93);
        chk("bp_hold_valid", {31'b0, rd_valid}, 32'd1);
        rd_ready = 1'b1;
        wait_done("bp_done");
        repeat (2) @(negedge clock);
        chk("bp_nrx", n_rx - n0, 32'd4);
        chk("bp_sb_empty", q_exp.size(), 32'd0);
        chk("bp_done_cnt", done_cnt - d0, 32'd1);
        q_wire.delete();

        // 4: zero length
        c0 = cs_falls;
        addr = 24'h100000;
        len = 16'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("zl_done", {31'b0, done}, 32'd1);
        chk("zl_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        chk("zl_done_once", {31'b0, done}, 32'd0);
        repeat (5) @(negedge clock);
        chk("zl_no_cs", cs_falls - c0, 32'd0);

        // 5: abort mid-address, then a one-byte read
        d0 = done_cnt;
        pulse_start(24'h100000, 16'd4);
        k0 = 0;
        while (m_bits < 12 && k0 < 3000) begin
            @(negedge clock);
            k0++;
        end
        chk("ab_reach_addr", {31'b0, (m_bits >= 12 && m_bits < 32)}, 32'd1);
        resetb = 1'b0;
        @(negedge clock);
        chk("ab_csb", {31'b0, flash_csb}, 32'd1);
        chk("ab_sck", {31'b0, flash_clk}, 32'd0);
        chk("ab_busy", {31'b0, busy}, 32'd0);
        resetb = 1'b1;
        repeat (10) @(negedge clock);
        chk("ab_no_done", done_cnt - d0, 32'd0);
        q_exp.delete();
        q_wire.delete();
        n0 = n_rx;
        q_exp.push_back(8'h41);
        pulse_start(24'h100002, 16'd1);
        wait_done("ab_one_done");
        repeat (2) @(negedge clock);
        chk("ab_one_nrx", n_rx - n0, 32'd1);
        chk("ab_one_sb_empty", q_exp.size(), 32'd0);
        chk_wire(24'h100002);

`ifdef SPI_FLASH_READER_FASTREAD_EN
        // 6: fast read with dummy cycles
        n0 = n_rx;
        dummy_hi = 0;
        q_exp.push_back(8'h93); q_exp.push_back(8'h00);
        pulse_start(24'h100000, 16'd2);
        wait_done("fr_done");
        repeat (2) @(negedge clock);
        chk("fr_nrx", n_rx - n0, 32'd2);
        chk("fr_dummy_low", dummy_hi, 32'd0);
        chk_wire(24'h100000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
